flag_wb_stage: RTL and testbench
================================

FLAG_WB_STAGE -- requirements
Module: flag_wb_stage

Interface
REQ-001 SHALL have: clk  input  1  sole clock, rising edge.
REQ-002 SHALL have: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have: in_valid  input  1  execute-stage entry valid.
REQ-004 SHALL have: in_ready  output  1  stage accepts entry this cycle.
REQ-005 SHALL have: in_cond  input  4  ARM condition field.
REQ-006 SHALL have: in_opcode  input  4  ALU opcode (0x0 AND .. 0xE MVN).
REQ-007 SHALL have: in_setflags  input  1  S bit.
REQ-008 SHALL have: in_rd  input  4  destination register.
REQ-009 SHALL have: alu_result  input  32  ALU result c.
REQ-010 SHALL have: alu_flags  input  4  ALU flags, bit0 N, bit1 Z, bit2 C, bit3 V.
REQ-011 SHALL have: shift_carry  input  1  operand-2 shifter carry-out.
REQ-012 SHALL have: out_valid  output  1  writeback entry valid.
REQ-013 SHALL have: out_ready  input  1  register file consumes entry.
REQ-014 SHALL have: out_data  output  32  writeback data.
REQ-015 SHALL have: out_rd  output  4  writeback register index.
REQ-016 SHALL have: out_we  output  1  register write enable.
REQ-017 SHALL have: flags_q  output  4  architectural NZCV, same bit order as alu_flags.
REQ-018 SHALL have: carry_out  output  1  equals flags_q[2]; drives ALU carry input.

Function
REQ-019 Accept SHALL occur when in_valid && in_ready.
REQ-020 On accept, condition SHALL be evaluated against flags_q pre-edge: 0 EQ Z, 1 NE !Z, 2 CS C, 3 CC !C, 4 MI N, 5 PL !N, 6 VS V, 7 VC !V, 8 HI C&!Z, 9 LS !C|Z, A GE N==V, B LT N!=V, C GT !Z&(N==V), D LE Z|(N!=V), E AL 1, F NV 0.
REQ-021 Flag write SHALL occur at the accept edge iff pass && (in_setflags || opcode in 0x8..0xB).
REQ-022 Arithmetic opcodes 0x2..0x7, 0xA, 0xB SHALL load all four NZCV from alu_flags.
REQ-023 Logical opcodes 0x0, 0x1, 0x8, 0x9, 0xC, 0xD, 0xE SHALL load N, Z from alu_flags, C from shift_carry, and SHALL retain V.
REQ-024 Opcode 0xF SHALL never update flags.
REQ-025 Every accepted entry SHALL be enqueued with out_data=alu_result, out_rd=in_rd, out_we=pass && opcode not in 0x8..0xB; failed-condition entries SHALL still be enqueued, with out_we=0.
REQ-026 Latency SHALL be 1 cycle: entry accepted at edge k is visible on out_* after edge k.
REQ-027 Output entry SHALL be held stable while out_valid && !out_ready.
REQ-028 Back-to-back dependent instructions SHALL be handled as follows: entry accepted at edge k+1 SHALL see flags written at edge k.

Reset
REQ-029 On reset: flags_q=0, out_valid=0, out_data=0, out_rd=0, out_we=0, buffer occupancy=0.
REQ-030 Reset SHALL dominate a coincident accept; entries held at reset SHALL be discarded with no flag write.

Configuration
REQ-031 Macro FLAG_WB_OUTBUF2_EN SHALL select output buffering.
REQ-032 Without FLAG_WB_OUTBUF2_EN: one-entry buffer; in_ready = !out_valid || out_ready (combinational); simultaneous pop and push allowed when full.
REQ-033 With FLAG_WB_OUTBUF2_EN: two-entry FIFO in order; in_ready registered, equal to (occupancy<2); simultaneous push and pop at occupancy 1 keeps occupancy 1; no push at occupancy 2 even with out_ready=1.
REQ-034 Flag and condition behaviour SHALL be identical in both configurations.

Structure
REQ-035 Shared package simplearm_pkg SHALL hold opcode constants, NZCV bit-index constants, and the condition-code enum.
REQ-036 Sub-module cond_check SHALL be a purely combinational (cond, nzcv) -> pass evaluator.

Verification
REQ-037 Reset, then in_cond=E, op ADD, S=1, alu_flags=0b0110 -> flags_q=0b0110 next cycle; out_we=1; out_data=alu_result.
REQ-038 CMP, alu_flags Z=1 (0b0010), then in_cond=0 EQ at edge k+1 -> out_we=1; with in_cond=1 NE instead -> out_we=0 and flags unchanged.
REQ-039 flags_q V=1, op ORR, S=1, shift_carry=1, alu_result=0x80000000 -> flags_q=0b1101 (N=1, C=1, V retained).
REQ-040 in_cond=F, op CMP -> no flag write; out_valid=1, out_we=0.
REQ-041 out_ready=0 with 3 consecutive in_valid -> one-entry: 1 accepted, in_ready=0; OUTBUF2: 2 accepted, then in_ready=0; releasing out_ready -> entries drain in order.
REQ-042 Assert reset while the buffer is full and an accept is pending -> out_valid=0 and flags_q=0 next cycle; pending entry has no effect.

Source files
------------

// File: rtl/simplearm_pkg.sv
// simplearm_pkg
// Shared definitions for the flag/writeback stage.
//   - ALU opcode constants (4-bit, 0x0 AND .. 0xE MVN, 0xF reserved)
//   - NZCV bit-index constants (bit0 N, bit1 Z, bit2 C, bit3 V)
//   - condition-code enum
//   - writeback entry struct and opcode classification helpers
package simplearm_pkg;

   localparam logic [3:0] OP_AND = 4'h0;
   localparam logic [3:0] OP_EOR = 4'h1;
   localparam logic [3:0] OP_SUB = 4'h2;
   localparam logic [3:0] OP_RSB = 4'h3;
   localparam logic [3:0] OP_ADD = 4'h4;
   localparam logic [3:0] OP_ADC = 4'h5;
   localparam logic [3:0] OP_SBC = 4'h6;
   localparam logic [3:0] OP_RSC = 4'h7;
   localparam logic [3:0] OP_TST = 4'h8;
   localparam logic [3:0] OP_TEQ = 4'h9;
   localparam logic [3:0] OP_CMP = 4'hA;
   localparam logic [3:0] OP_CMN = 4'hB;
   localparam logic [3:0] OP_ORR = 4'hC;
   localparam logic [3:0] OP_MOV = 4'hD;
   localparam logic [3:0] OP_MVN = 4'hE;
   localparam logic [3:0] OP_RSV = 4'hF;

   localparam int FLAG_N = 0;
   localparam int FLAG_Z = 1;
   localparam int FLAG_C = 2;
   localparam int FLAG_V = 3;

   typedef enum logic [3:0] {
      COND_EQ = 4'h0,
      COND_NE = 4'h1,
      COND_CS = 4'h2,
      COND_CC = 4'h3,
      COND_MI = 4'h4,
      COND_PL = 4'h5,
      COND_VS = 4'h6,
      COND_VC = 4'h7,
      COND_HI = 4'h8,
      COND_LS = 4'h9,
      COND_GE = 4'hA,
      COND_LT = 4'hB,
      COND_GT = 4'hC,
      COND_LE = 4'hD,
      COND_AL = 4'hE,
      COND_NV = 4'hF
   } cond_e;

   typedef struct packed {
      logic [31:0] data;
      logic [3:0]  rd;
      logic        we;
   } wb_entry_t;

   // TST/TEQ/CMP/CMN: always write flags, never write a register
   function automatic logic op_is_compare(input logic [3:0] op);
      return (op[3:2] == 2'b10);
   endfunction

   // Arithmetic ops take all four flags from the adder
   function automatic logic op_is_arith(input logic [3:0] op);
      return ((op >= OP_SUB) && (op <= OP_RSC)) || (op == OP_CMP) || (op == OP_CMN);
   endfunction

endpackage

// File: rtl/cond_check.sv
// cond_check
// Purely combinational ARM condition evaluator.
// Ports:
//   cond  in  4  condition field
//   nzcv  in  4  flags, bit0 N, bit1 Z, bit2 C, bit3 V
//   pass  out 1  condition satisfied
module cond_check
   import simplearm_pkg::*;
(
   input  logic [3:0] cond,
   input  logic [3:0] nzcv,
   output logic       pass
);

   logic w_n, w_z, w_c, w_v;

   assign w_n = nzcv[FLAG_N];
   assign w_z = nzcv[FLAG_Z];
   assign w_c = nzcv[FLAG_C];
   assign w_v = nzcv[FLAG_V];

   always_comb begin
      pass = 1'b0;
      case (cond)
         COND_EQ: pass = w_z;
         COND_NE: pass = !w_z;
         COND_CS: pass = w_c;
         COND_CC: pass = !w_c;
         COND_MI: pass = w_n;
         COND_PL: pass = !w_n;
         COND_VS: pass = w_v;
         COND_VC: pass = !w_v;
         COND_HI: pass = w_c && !w_z;
         COND_LS: pass = !w_c || w_z;
         COND_GE: pass = (w_n == w_v);
         COND_LT: pass = (w_n != w_v);
         COND_GT: pass = !w_z && (w_n == w_v);
         COND_LE: pass = w_z || (w_n != w_v);
         COND_AL: pass = 1'b1;
         default: pass = 1'b0;
      endcase
   end

endmodule

// File: rtl/flag_wb_stage.sv
// flag_wb_stage
// Condition evaluation, NZCV flag update and writeback output buffer.
// Configuration macro: FLAG_WB_OUTBUF2_EN
//   undefined : one-entry output buffer, in_ready combinational
//   defined   : two-entry in-order FIFO, in_ready registered (occupancy < 2)
// Ports:
//   clk, reset                  clock and synchronous active-high reset
//   in_valid/in_ready           execute-stage handshake
//   in_cond, in_opcode          condition field, ALU opcode
//   in_setflags, in_rd          S bit, destination register
//   alu_result, alu_flags       ALU result and NZCV
//   shift_carry                 shifter carry-out (C source for logical ops)
//   out_valid/out_ready         writeback handshake
//   out_data, out_rd, out_we    writeback entry
//   flags_q, carry_out          architectural NZCV, C bit
module flag_wb_stage
   import simplearm_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [3:0]  in_cond,
   input  logic [3:0]  in_opcode,
   input  logic        in_setflags,
   input  logic [3:0]  in_rd,
   input  logic [31:0] alu_result,
   input  logic [3:0]  alu_flags,
   input  logic        shift_carry,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data,
   output logic [3:0]  out_rd,
   output logic        out_we,
   output logic [3:0]  flags_q,
   output logic        carry_out
);

   logic [3:0] r_flags;
   logic [3:0] w_flags_nxt;
   logic       w_pass;
   logic       w_accept;
   logic       w_flag_wr;
   wb_entry_t  w_push_entry;

   cond_check u_cond_check (
      .cond (in_cond),
      .nzcv (r_flags),
      .pass (w_pass)
   );

   assign w_accept  = in_valid && in_ready;
   assign w_flag_wr = w_accept && w_pass
                   && (in_setflags || op_is_compare(in_opcode))
                   && (in_opcode != OP_RSV);

   // Logical ops take C from the shifter and keep V
   always_comb begin
      w_flags_nxt = r_flags;
      if (op_is_arith(in_opcode)) begin
         w_flags_nxt = alu_flags;
      end else begin
         w_flags_nxt[FLAG_N] = alu_flags[FLAG_N];
         w_flags_nxt[FLAG_Z] = alu_flags[FLAG_Z];
         w_flags_nxt[FLAG_C] = shift_carry;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_flags <= 4'h0;
      end else if (w_flag_wr) begin
         r_flags <= w_flags_nxt;
      end
   end

   assign flags_q   = r_flags;
   assign carry_out = r_flags[FLAG_C];

   // Failed-condition entries still travel down the pipe, just without a write
   assign w_push_entry = '{data: alu_result,
                           rd:   in_rd,
                           we:   w_pass && !op_is_compare(in_opcode)};

`ifdef FLAG_WB_OUTBUF2_EN
   wb_entry_t  r_mem [2];
   logic       r_rd_ptr;
   logic       r_wr_ptr;
   logic [1:0] r_count;
   logic [1:0] w_count_nxt;
   logic       r_in_ready;
   logic       w_pop;

   assign w_pop       = (r_count != 2'd0) && out_ready;
   assign w_count_nxt = r_count + {1'b0, w_accept} - {1'b0, w_pop};

   always_ff @(posedge clk) begin
      if (reset) begin
         r_mem[0]   <= '0;
         r_mem[1]   <= '0;
         r_rd_ptr   <= 1'b0;
         r_wr_ptr   <= 1'b0;
         r_count    <= 2'd0;
         r_in_ready <= 1'b1;
      end else begin
         if (w_accept) begin
            r_mem[r_wr_ptr] <= w_push_entry;
            r_wr_ptr        <= ~r_wr_ptr;
         end
         if (w_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         r_count    <= w_count_nxt;
         // ready for next cycle is known from the post-edge occupancy
         r_in_ready <= (w_count_nxt != 2'd2);
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = (r_count != 2'd0);
   assign out_data  = r_mem[r_rd_ptr].data;
   assign out_rd    = r_mem[r_rd_ptr].rd;
   assign out_we    = r_mem[r_rd_ptr].we;
`else
   wb_entry_t r_entry;
   logic      r_valid;

   // Full buffer may still accept when the consumer drains it this cycle
   assign in_ready = !r_valid || out_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_entry <= '0;
         r_valid <= 1'b0;
      end else if (w_accept) begin
         r_entry <= w_push_entry;
         r_valid <= 1'b1;
      end else if (out_ready) begin
         r_valid <= 1'b0;
      end
   end

   assign out_valid = r_valid;
   assign out_data  = r_entry.data;
   assign out_rd    = r_entry.rd;
   assign out_we    = r_entry.we;
`endif

endmodule

// File: tb/tb_flag_wb_stage.sv
// tb_flag_wb_stage
// Directed and randomized bench for flag_wb_stage with a queue-based
// reference model. Honours FLAG_WB_OUTBUF2_EN for buffer depth.
module tb_flag_wb_stage;

`ifdef FLAG_WB_OUTBUF2_EN
   localparam int CAP = 2;
`else
   localparam int CAP = 1;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  in_cond;
   logic [3:0]  in_opcode;
   logic        in_setflags;
   logic [3:0]  in_rd;
   logic [31:0] alu_result;
   logic [3:0]  alu_flags;
   logic        shift_carry;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [3:0]  out_rd;
   logic        out_we;
   logic [3:0]  flags_q;
   logic        carry_out;

   flag_wb_stage dut (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_cond     (in_cond),
      .in_opcode   (in_opcode),
      .in_setflags (in_setflags),
      .in_rd       (in_rd),
      .alu_result  (alu_result),
      .alu_flags   (alu_flags),
      .shift_carry (shift_carry),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .out_rd      (out_rd),
      .out_we      (out_we),
      .flags_q     (flags_q),
      .carry_out   (carry_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] data;
      logic [3:0]  rd;
      logic        we;
   } ent_t;

   ent_t       mq[$];
   logic [3:0] m_flags;
   int         n_total = 0;
   int         n_pass  = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic bit m_cond(input logic [3:0] c, input logic [3:0] f);
      bit n, z, cy, v;
      n = f[0]; z = f[1]; cy = f[2]; v = f[3];
      case (c)
         4'd0:  return z;
         4'd1:  return !z;
         4'd2:  return cy;
         4'd3:  return !cy;
         4'd4:  return n;
         4'd5:  return !n;
         4'd6:  return v;
         4'd7:  return !v;
         4'd8:  return cy && !z;
         4'd9:  return !cy || z;
         4'd10: return n == v;
         4'd11: return n != v;
         4'd12: return !z && (n == v);
         4'd13: return z || (n != v);
         4'd14: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   function automatic bit m_ready(input bit ordy);
      if (CAP == 1) return (mq.size() == 0) || ordy;
      return mq.size() < 2;
   endfunction

   task automatic drive(input logic v, input logic [3:0] c, input logic [3:0] op,
                        input logic s, input logic [3:0] rd, input logic [31:0] res,
                        input logic [3:0] fl, input logic sc, input logic ordy,
                        input logic rst);
      in_valid = v; in_cond = c; in_opcode = op; in_setflags = s; in_rd = rd;
      alu_result = res; alu_flags = fl; shift_carry = sc; out_ready = ordy;
      reset = rst;
   endtask

   // One clock: check in_ready mid-cycle, advance the model, check outputs
   task automatic step(input string tag, output bit got_acc);
      bit   exp_rdy, acc, pop, pc, rst, s, sc;
      logic [3:0]  op, fl, rd, cnd;
      logic [31:0] res;
      ent_t e;
      @(negedge clk);
      exp_rdy = m_ready(out_ready === 1'b1);
      check({tag, " in_ready"}, in_ready, exp_rdy);
      got_acc = (in_valid === 1'b1) && (in_ready === 1'b1);
      acc = (in_valid === 1'b1) && exp_rdy;
      pop = (mq.size() > 0) && (out_ready === 1'b1);
      rst = (reset === 1'b1);
      cnd = in_cond; op = in_opcode; s = in_setflags; rd = in_rd;
      res = alu_result; fl = alu_flags; sc = shift_carry;
      pc  = m_cond(cnd, m_flags);
      @(posedge clk);
      #1;
      if (rst) begin
         m_flags = 4'h0;
         mq.delete();
      end else begin
         if (pop) void'(mq.pop_front());
         if (acc) begin
            if (pc && (s || (op >= 8 && op <= 11)) && op != 15) begin
               if ((op >= 2 && op <= 7) || op == 10 || op == 11)
                  m_flags = fl;
               else
                  m_flags = {m_flags[3], sc, fl[1], fl[0]};
            end
            e.data = res; e.rd = rd; e.we = pc && !(op >= 8 && op <= 11);
            mq.push_back(e);
         end
      end
      check({tag, " out_valid"}, out_valid, mq.size() > 0);
      check({tag, " flags_q"}, flags_q, m_flags);
      check({tag, " carry_out"}, carry_out, m_flags[2]);
      if (mq.size() > 0) begin
         check({tag, " out_data"}, out_data, mq[0].data);
         check({tag, " out_rd"}, out_rd, mq[0].rd);
         check({tag, " out_we"}, out_we, mq[0].we);
      end
   endtask

   initial begin
      bit acc;
      int acc_cnt;
      m_flags = 4'h0;
      drive(0, 4'hE, 4'h0, 0, 4'h0, 32'h0, 4'h0, 0, 0, 1);
      @(posedge clk);
      @(posedge clk);
      #1;
      check("reset flags_q", flags_q, 4'h0);
      check("reset out_valid", out_valid, 1'b0);
      check("reset out_data", out_data, 32'h0);
      check("reset out_rd", out_rd, 4'h0);
      check("reset out_we", out_we, 1'b0);

      // ADD, S=1, AL
      drive(1, 4'hE, 4'h4, 1, 4'h3, 32'h1234_5678, 4'b0110, 0, 1, 0);
      step("add", acc);
      check("add flags", flags_q, 4'b0110);
      check("add we", out_we, 1'b1);
      check("add data", out_data, 32'h1234_5678);

      // CMP sets Z, then EQ passes, then NE fails
      drive(1, 4'hE, 4'hA, 0, 4'h1, 32'h0, 4'b0010, 0, 1, 0);
      step("cmp", acc);
      check("cmp we", out_we, 1'b0);
      drive(1, 4'h0, 4'h4, 0, 4'h5, 32'hAA, 4'b0000, 0, 1, 0);
      step("eq", acc);
      check("eq we", out_we, 1'b1);
      drive(1, 4'h1, 4'h4, 1, 4'h6, 32'hBB, 4'b1111, 1, 1, 0);
      step("ne", acc);
      check("ne we", out_we, 1'b0);
      check("ne flags", flags_q, 4'b0010);

      // V=1 then ORR keeps V, takes C from shifter
      drive(1, 4'hE, 4'h4, 1, 4'h2, 32'h0, 4'b1000, 0, 1, 0);
      step("setv", acc);
      drive(1, 4'hE, 4'hC, 1, 4'h7, 32'h8000_0000, 4'b0001, 1, 1, 0);
      step("orr", acc);
      check("orr flags", flags_q, 4'b1101);
      check("orr carry", carry_out, 1'b1);

      // NV CMP: no flag write, entry still delivered
      drive(1, 4'hF, 4'hA, 1, 4'h8, 32'h55, 4'b0000, 0, 1, 0);
      step("nv", acc);
      check("nv flags", flags_q, 4'b1101);
      check("nv valid", out_valid, 1'b1);
      check("nv we", out_we, 1'b0);

      // Backpressure
      drive(0, 4'hE, 4'h4, 0, 4'h0, 32'h0, 4'h0, 0, 1, 0);
      step("drain", acc);
      acc_cnt = 0;
      for (int i = 0; i < 3; i++) begin
         drive(1, 4'hE, 4'hD, 0, 4'(i + 1), 32'h100 + 32'(i), 4'h0, 0, 0, 0);
         step("bp", acc);
         if (acc) acc_cnt++;
      end
      check("bp accepted", acc_cnt, CAP);
      check("bp first data", out_data, 32'h100);
      @(negedge clk);
      check("bp in_ready", in_ready, 1'b0);
      @(posedge clk);
      #1;
      for (int i = 0; i < CAP; i++) begin
         drive(0, 4'hE, 4'h4, 0, 4'h0, 32'h0, 4'h0, 0, 1, 0);
         step("release", acc);
      end
      check("release empty", out_valid, 1'b0);

      // Reset while full with an accept pending
      for (int i = 0; i < CAP; i++) begin
         drive(1, 4'hE, 4'h4, 1, 4'h9, 32'h200 + 32'(i), 4'b1010, 0, 0, 0);
         step("fill", acc);
      end
      drive(1, 4'hE, 4'h4, 1, 4'hA, 32'h300, 4'b1111, 1, 1, 1);
      step("rst", acc);
      check("rst valid", out_valid, 1'b0);
      check("rst flags", flags_q, 4'h0);
      check("rst data", out_data, 32'h0);
      check("rst we", out_we, 1'b0);

      // Randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         drive(($urandom_range(0, 3) != 0), 4'($urandom), 4'($urandom),
               1'($urandom), 4'($urandom), $urandom, 4'($urandom),
               1'($urandom), ($urandom_range(0, 2) != 0),
               ($urandom_range(0, 59) == 0));
         step("rand", acc);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
